// File: rtl/fifo_stream_if.sv
// Handshake and status bundle for fifo_stream.
// slave: the FIFO itself. master: the producer/consumer environment.
interface fifo_stream_if #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] push_data_I;
  logic              push_valid_I;
  logic              push_ready_O;
  logic [DATA_W-1:0] pop_data_O;
  logic              pop_valid_O;
  logic              pop_ready_I;
  logic              flush_I;
  logic              err_clear_I;
  logic [CW-1:0]     count_O;
  logic              almost_full_O;
  logic              almost_empty_O;
  logic              overflow_O;
  logic              underflow_O;

  modport slave (
    input  push_data_I, push_valid_I, pop_ready_I, flush_I, err_clear_I,
    output push_ready_O, pop_data_O, pop_valid_O, count_O,
           almost_full_O, almost_empty_O, overflow_O, underflow_O
  );

  modport master (
    output push_data_I, push_valid_I, pop_ready_I, flush_I, err_clear_I,
    input  push_ready_O, pop_data_O, pop_valid_O, count_O,
           almost_full_O, almost_empty_O, overflow_O, underflow_O
  );
endinterface

// File: rtl/fifo_stream.sv
// First-word-fall-through circular-buffer FIFO with valid/ready on both
// sides, occupancy count, almost-full/empty thresholds, synchronous flush
// and sticky overflow/underflow flags.
module fifo_stream #(
  parameter int DATA_W   = 9,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input logic           clk_I,
  input logic           reset_I,
  fifo_stream_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CW-1:0]     wr_ptr, rd_ptr, count;
  logic              ovf, unf;
  logic              full, empty;
  logic              push_fire, pop_fire;
  logic              ovf_set, unf_set;

  // Pointer MSB is the wrap bit: equal low bits + different wrap = full.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[CW-1] != rd_ptr[CW-1]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Flush swallows same-cycle transfers, so they neither fire nor flag errors.
  assign push_fire = bus.push_valid_I & ~full  & ~bus.flush_I;
  assign pop_fire  = bus.pop_ready_I  & ~empty & ~bus.flush_I;
  assign ovf_set   = bus.push_valid_I & full   & ~bus.flush_I;
  assign unf_set   = bus.pop_ready_I  & empty  & ~bus.flush_I;

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk_I) begin
    if (push_fire) mem[wr_ptr[AW-1:0]] <= bus.push_data_I;
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk_I or posedge reset_I) begin
    if (reset_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.flush_I) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + ONE;
      if (pop_fire)  rd_ptr <= rd_ptr + ONE;
      if (push_fire && !pop_fire)      count <= count + ONE;
      else if (pop_fire && !push_fire) count <= count - ONE;
    end
  end

  // Sticky error flags; a same-cycle set beats a clear.
  always_ff @(posedge clk_I or posedge reset_I) begin
    if (reset_I) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)              ovf <= 1'b1;
      else if (bus.err_clear_I) ovf <= 1'b0;
      if (unf_set)              unf <= 1'b1;
      else if (bus.err_clear_I) unf <= 1'b0;
    end
  end

  // Outputs; thresholds come from the registered count so they never glitch.
  assign bus.push_ready_O   = ~full;
  assign bus.pop_valid_O    = ~empty;
  assign bus.pop_data_O     = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign bus.count_O        = count;
  assign bus.almost_full_O  = (count >= AF_L);
  assign bus.almost_empty_O = (count <= AE_L);
  assign bus.overflow_O     = ovf;
  assign bus.underflow_O    = unf;
endmodule

// File: tb/tb_fifo_stream.sv
// Scoreboard bench for fifo_stream: accepted pushes queue their data,
// every pop compares the head against the queue front.
module tb_fifo_stream;
  localparam int DATA_W = 9;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_stream_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  fifo_stream #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(DEPTH-2), .AE_LEVEL(2))
    dut (.clk_I(clk), .reset_I(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  logic [DATA_W-1:0] sb[$];
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare all observable state against the model.
  task automatic check_state();
    int sz;
    sz = sb.size();
    chk("count", 32'(bus.count_O), 32'(sz));
    chk("pop_valid", 32'(bus.pop_valid_O), 32'(sz != 0));
    chk("push_ready", 32'(bus.push_ready_O), 32'(sz != DEPTH));
    chk("almost_full", 32'(bus.almost_full_O), 32'(sz >= DEPTH-2));
    chk("almost_empty", 32'(bus.almost_empty_O), 32'(sz <= 2));
    chk("overflow", 32'(bus.overflow_O), 32'(m_ovf));
    chk("underflow", 32'(bus.underflow_O), 32'(m_unf));
    if (sz == 0) chk("pop_data_empty", 32'(bus.pop_data_O), 32'd0);
    else         chk("pop_data_head", 32'(bus.pop_data_O), 32'(sb[0]));
  endtask

  // One clock cycle of stimulus; inputs set just after an edge.
  task automatic step(input logic pv, input logic [DATA_W-1:0] pd, input logic pr,
                      input logic fl, input logic ec);
    logic full_m, empty_m, ovs, uns;
    logic [DATA_W-1:0] exp;
    bus.push_valid_I = pv;
    bus.push_data_I  = pd;
    bus.pop_ready_I  = pr;
    bus.flush_I      = fl;
    bus.err_clear_I  = ec;
    @(negedge clk);
    full_m  = (sb.size() == DEPTH);
    empty_m = (sb.size() == 0);
    if (fl) begin
      sb.delete();
    end else begin
      if (pr && !empty_m) begin
        exp = sb.pop_front();
        chk("pop_order", 32'(bus.pop_data_O), 32'(exp));
      end
      if (pv && !full_m) sb.push_back(pd);
    end
    ovs = pv && full_m && !fl;
    uns = pr && empty_m && !fl;
    m_ovf = ovs ? 1'b1 : (ec ? 1'b0 : m_ovf);
    m_unf = uns ? 1'b1 : (ec ? 1'b0 : m_unf);
    @(posedge clk);
    #1;
    bus.push_valid_I = 1'b0;
    bus.pop_ready_I  = 1'b0;
    bus.flush_I      = 1'b0;
    bus.err_clear_I  = 1'b0;
    check_state();
  endtask

  task automatic push(input logic [DATA_W-1:0] d); step(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic pop();                            step(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask

  initial begin
    bus.push_valid_I = 1'b0;
    bus.push_data_I  = '0;
    bus.pop_ready_I  = 1'b0;
    bus.flush_I      = 1'b0;
    bus.err_clear_I  = 1'b0;

    // Power-on reset values
    #12;
    check_state();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-cycle with 7 entries
    for (int i = 0; i < 7; i++) push(9'(i + 40));
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    check_state();
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    push(9'h1A5);
    chk("post_reset_data", 32'(bus.pop_data_O), 32'h1A5);
    pop();

    // Fill, overflow, drain
    for (int i = 0; i < DEPTH; i++) push(9'(i));
    push(9'h0FF);
    for (int i = 0; i < DEPTH; i++) pop();

    // Wrap-around
    for (int i = 0; i < 20; i++) push(9'(i + 300));
    for (int i = 0; i < 20; i++) pop();
    for (int i = 0; i < DEPTH; i++) push(9'(i + 100));
    for (int i = 0; i < DEPTH; i++) pop();

    // Sustained concurrent push/pop at count 5
    for (int i = 0; i < 5; i++) push(9'(i + 200));
    for (int i = 0; i < 50; i++) step(1'b1, 9'(i + 210), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) pop();

    // At full, a same-cycle push is refused while the pop fires
    for (int i = 0; i < DEPTH; i++) push(9'($urandom_range(0, 511)));
    step(1'b1, 9'h077, 1'b1, 1'b0, 1'b0);
    chk("full_pushpop_count", 32'(bus.count_O), 32'd31);
    for (int i = 0; i < DEPTH-1; i++) pop();

    // Underflow and clear
    pop();
    step(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("unf_set_wins", 32'(bus.underflow_O), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("unf_cleared", 32'(bus.underflow_O), 32'd0);

    // Flush with count 12 and overflow set
    for (int i = 0; i < DEPTH; i++) push(9'(i + 400));
    push(9'h1FF);
    for (int i = 0; i < 20; i++) pop();
    step(1'b1, 9'h055, 1'b0, 1'b1, 1'b0);
    chk("flush_count", 32'(bus.count_O), 32'd0);
    chk("flush_ovf_kept", 32'(bus.overflow_O), 32'd1);
    push(9'h0AB);
    pop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_stream.md
# fifo_stream

Parametrised first-word-fall-through FIFO with valid/ready handshakes on both sides. Next-generation replacement for the shift-register FIFO in the pipeline's buffering path. Uses a circular buffer with read/write pointers, so a push costs one write and no data movement. Adds occupancy count, almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags.

## Interface

- DATA_W, 9, payload width in bits (≥1)
- DEPTH, 32, number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2, almost_full_O asserts when count ≥ AF_LEVEL
- AE_LEVEL, 2, almost_empty_O asserts when count ≤ AE_LEVEL
- CW = $clog2(DEPTH)+1 (local), width of count and pointers

Ports:
- clk_I  in  1  clock; all state changes on the rising edge
- reset_I  in  1  asynchronous, active-high reset
- push_data_I  in  DATA_W  write payload
- push_valid_I  in  1  write request
- push_ready_O  out  1  FIFO can accept; = !full
- pop_data_O  out  DATA_W  head entry; 0 when pop_valid_O=0
- pop_valid_O  out  1  head entry valid; = (count≠0)
- pop_ready_I  in  1  consumer takes head this cycle
- flush_I  in  1  synchronous empty
- err_clear_I  in  1  clears sticky error flags
- count_O  out  CW  current occupancy, 0..DEPTH
- almost_full_O  out  1  count ≥ AF_LEVEL
- almost_empty_O  out  1  count ≤ AE_LEVEL
- overflow_O  out  1  sticky: push attempted while full
- underflow_O  out  1  sticky: pop attempted while empty

## Operation

- Storage: DEPTH×DATA_W array, not reset. wr_ptr/rd_ptr are CW bits wide; the low bits index the array and the MSB is the wrap bit. Full = (low bits equal, MSBs differ). Empty = pointers equal.
- Push fires when push_valid_I & push_ready_O: mem[wr_ptr] ← push_data_I, wr_ptr+1 (wraps naturally at 2·DEPTH).
- Pop fires when pop_ready_I & pop_valid_O: rd_ptr+1.
- pop_data_O = mem[rd_ptr[CW-2:0]] when non-empty (combinational read), else 0.
- count_O is a registered counter: +1 on push only, −1 on pop only, unchanged when both or neither fire. It always equals wr_ptr−rd_ptr.
- push_ready_O depends only on state, not on pop_ready_I. When full, a push is refused even if a pop fires in the same cycle.
- When empty, a push and a pop_ready_I in the same cycle: push fires, pop does not. No pass-through.
- Errors:
  - overflow_O sets on push_valid_I & !push_ready_O.
  - underflow_O sets on pop_ready_I & !pop_valid_O.
  - Both clear on err_clear_I. If set and clear occur in the same cycle, set wins.
- flush_I: pointers and count go to 0 next edge. Flush overrides push/pop in the same cycle; those transfers are discarded and not counted as errors. Error flags are unaffected by flush.
- almost_full_O/almost_empty_O are derived from registered count_O (glitch-free).

## Timing

- Reset (async assert, sync release): count_O=0, pop_valid_O=0, pop_data_O=0, push_ready_O=1, almost_empty_O=1, almost_full_O=0 (AF_LEVEL>0), overflow_O=0, underflow_O=0.
- Reset mid-operation discards all contents immediately; outputs take reset values without waiting for a clock edge.
- Write-to-read latency: data pushed at edge N is visible on pop_data_O with pop_valid_O=1 after edge N (usable in cycle N+1).
- Full assertion: the DEPTH-th push at edge N drops push_ready_O after edge N. One pop at edge M restores it after edge M.
- Throughput: one push and one pop per cycle sustained whenever 0<count<DEPTH.
- Flags (count, almost_*, errors) update on the same edge as the causing event.

## Test plan

- Reset check:
  - Assert reset_I mid-cycle with count=7 → outputs go to reset values asynchronously.
  - After release, push 0x1A5 → pop_data_O=0x1A5, count_O=1 next cycle.
- Fill and overflow:
  - Push 0..31 with pop_ready_I=0 → push_ready_O=0 and count_O=32 after the 32nd push; almost_full_O high from count 30.
  - Extra push → overflow_O=1, contents unchanged.
  - Drain → 0..31 in order.
- Wrap-around:
  - Push 20, pop 20, then push 32 values 100..131 → all popped in order; count_O passes 0→32→0.
- Concurrent push/pop at count=5 for 50 cycles → count_O stays 5, output order preserved. At count=32 with pop_ready_I=1 and push_valid_I=1 → only the pop fires, count_O=31.
- Underflow and clear:
  - Pop while empty → underflow_O=1.
  - err_clear_I together with a new empty pop → underflow_O stays 1.
  - err_clear_I alone → flag cleared.
- Flush: with count=12, flush_I plus push in the same cycle → count_O=0, pop_valid_O=0, overflow_O unchanged. Next push/pop round-trip works.
